// File: rtl/ram8_ctrl_if.sv
// Host and ram8 side signal bundle for ram8_ctrl.
// The controller takes the slave modport; the host/ram model takes the master modport.
interface ram8_ctrl_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [2:0]  rd_addr;
    logic        rd_data_valid;
    logic [15:0] rd_data;
    logic        clr_start;
    logic [15:0] clr_value;
    logic        busy;
    logic [15:0] ram_in;
    logic [2:0]  ram_address;
    logic        ram_load;
    logic [15:0] ram_out;

    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, clr_start, clr_value, ram_out,
        output wr_ready, rd_ready, rd_data_valid, rd_data, busy, ram_in, ram_address, ram_load
    );

    modport master (
        output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, clr_start, clr_value, ram_out,
        input  wr_ready, rd_ready, rd_data_valid, rd_data, busy, ram_in, ram_address, ram_load
    );
endinterface

// File: rtl/ram8_ctrl.sv
// Request sequencer for an 8x16 ram8: clear > write > read arbitration, 8-cycle clear sweep.
// Optional RAM8_CTRL_STATS_EN adds wr_count_o, a wrapping count of accepted host writes.
module ram8_ctrl #(
    parameter bit          CLR_AUTO   = 1'b0,
    parameter logic [15:0] RESET_FILL = 16'h0000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    ram8_ctrl_if.slave  bus
`ifdef RAM8_CTRL_STATS_EN
    ,
    output logic [15:0] wr_count_o
`endif
);
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [2:0]  clr_idx_q, clr_idx_d;
    logic [15:0] clr_val_q, clr_val_d;
    logic        auto_q;
    logic [15:0] rd_data_q;
    logic        rd_vld_q;

    logic        wr_rdy, rd_rdy, ld;
    logic [2:0]  addr;
    logic [15:0] din;
    logic        wr_acc, rd_acc;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        clr_val_d = clr_val_q;
        wr_rdy    = 1'b0;
        rd_rdy    = 1'b0;
        ld        = 1'b0;
        addr      = bus.rd_addr;
        din       = bus.wr_data;
        if (state_q == S_CLEAR) begin
            ld        = 1'b1;
            addr      = clr_idx_q;
            din       = clr_val_q;
            clr_idx_d = clr_idx_q + 3'd1;
            if (clr_idx_q == 3'd7) state_d = S_IDLE;
        end else if (bus.clr_start || auto_q) begin
            // The post-reset automatic sweep outranks a host clear request.
            state_d   = S_CLEAR;
            clr_idx_d = 3'd0;
            clr_val_d = auto_q ? RESET_FILL : bus.clr_value;
        end else if (!reset_i) begin
            wr_rdy = 1'b1;
            rd_rdy = !bus.wr_valid;
            if (bus.wr_valid) begin
                ld   = 1'b1;
                addr = bus.wr_addr;
            end
        end
    end

    assign wr_acc = bus.wr_valid & wr_rdy;
    assign rd_acc = bus.rd_valid & rd_rdy;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            clr_idx_q <= 3'd0;
            clr_val_q <= 16'h0000;
            auto_q    <= CLR_AUTO;
            rd_data_q <= 16'h0000;
            rd_vld_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            clr_val_q <= clr_val_d;
            auto_q    <= 1'b0;
            rd_vld_q  <= rd_acc;
            if (rd_acc) rd_data_q <= bus.ram_out;
        end
    end

    assign bus.wr_ready      = wr_rdy;
    assign bus.rd_ready      = rd_rdy;
    assign bus.ram_load      = ld;
    assign bus.ram_address   = addr;
    assign bus.ram_in        = din;
    assign bus.busy          = (state_q == S_CLEAR);
    assign bus.rd_data       = rd_data_q;
    assign bus.rd_data_valid = rd_vld_q;

`ifdef RAM8_CTRL_STATS_EN
    logic [15:0] wr_cnt_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)     wr_cnt_q <= 16'h0000;
        else if (wr_acc) wr_cnt_q <= wr_cnt_q + 16'd1;
    end

    assign wr_count_o = wr_cnt_q;
`endif
endmodule

// File: tb/tb_ram8_ctrl.sv
// Bench for ram8_ctrl: behavioural ram8 models, a memory-level reference model and random traffic.
// A second instance exercises the automatic post-reset sweep.
module tb_ram8_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst1;
    ram8_ctrl_if b0();
    ram8_ctrl_if b1();

    logic [15:0] ram0 [8];
    logic [15:0] ram1 [8];
    always @(posedge clk) if (b0.ram_load) ram0[b0.ram_address] <= b0.ram_in;
    always @(posedge clk) if (b1.ram_load) ram1[b1.ram_address] <= b1.ram_in;
    assign b0.ram_out = ram0[b0.ram_address];
    assign b1.ram_out = ram1[b1.ram_address];

`ifdef RAM8_CTRL_STATS_EN
    logic [15:0] wc0, wc1;
`endif

    ram8_ctrl #(.CLR_AUTO(1'b0), .RESET_FILL(16'h0000)) dut0 (
        .clk_i(clk), .reset_i(rst0), .bus(b0)
`ifdef RAM8_CTRL_STATS_EN
        , .wr_count_o(wc0)
`endif
    );

    ram8_ctrl #(.CLR_AUTO(1'b1), .RESET_FILL(16'h0042)) dut1 (
        .clk_i(clk), .reset_i(rst1), .bus(b1)
`ifdef RAM8_CTRL_STATS_EN
        , .wr_count_o(wc1)
`endif
    );

    int n_chk = 0;
    int n_fail = 0;

    // Reference state: expected memory contents, remaining sweep cycles, pending response.
    logic [15:0] m_mem [8];
    int          m_left;
    int          m_idx;
    logic [15:0] m_val;
    logic        m_rv;
    logic [15:0] m_rd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input logic wv, input logic [2:0] wa, input logic [15:0] wd,
                       input logic rv, input logic [2:0] ra, input logic cs, input logic [15:0] cv);
        logic ewr, err;
        chk("rd_data_valid", {31'd0, b0.rd_data_valid}, {31'd0, m_rv});
        chk("rd_data", {16'd0, b0.rd_data}, {16'd0, m_rd});
        chk("busy", {31'd0, b0.busy}, (m_left > 0) ? 32'd1 : 32'd0);
        b0.wr_valid = wv; b0.wr_addr = wa; b0.wr_data = wd;
        b0.rd_valid = rv; b0.rd_addr = ra;
        b0.clr_start = cs; b0.clr_value = cv;
        #1;
        ewr = (m_left == 0) && !cs;
        err = ewr && !wv;
        chk("wr_ready", {31'd0, b0.wr_ready}, {31'd0, ewr});
        chk("rd_ready", {31'd0, b0.rd_ready}, {31'd0, err});
        chk("ram_load", {31'd0, b0.ram_load}, ((m_left > 0) || (ewr && wv)) ? 32'd1 : 32'd0);
        if (m_left > 0) begin
            chk("sweep_addr", {29'd0, b0.ram_address}, m_idx);
            chk("sweep_in", {16'd0, b0.ram_in}, {16'd0, m_val});
        end else if (ewr && wv) begin
            chk("wr_addr_out", {29'd0, b0.ram_address}, {29'd0, wa});
            chk("wr_in_out", {16'd0, b0.ram_in}, {16'd0, wd});
        end
        @(posedge clk);
        m_rv = 1'b0;
        if (m_left > 0) begin
            m_mem[m_idx] = m_val;
            m_idx++;
            m_left--;
        end else if (cs) begin
            m_left = 8; m_idx = 0; m_val = cv;
        end else if (wv) begin
            m_mem[wa] = wd;
        end else if (rv) begin
            m_rv = 1'b1; m_rd = m_mem[ra];
        end
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 1'b0, 16'h0);
    endtask

    task automatic rd1(input logic [2:0] a, input logic [15:0] exp);
        b1.rd_valid = 1'b1; b1.rd_addr = a;
        @(posedge clk); @(negedge clk);
        b1.rd_valid = 1'b0;
        chk("auto_rvld", {31'd0, b1.rd_data_valid}, 32'd1);
        chk("auto_rdata", {16'd0, b1.rd_data}, {16'd0, exp});
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1;
        b0.wr_valid = 0; b0.wr_addr = 0; b0.wr_data = 0; b0.rd_valid = 0; b0.rd_addr = 0;
        b0.clr_start = 0; b0.clr_value = 0;
        b1.wr_valid = 0; b1.wr_addr = 0; b1.wr_data = 0; b1.rd_valid = 0; b1.rd_addr = 0;
        b1.clr_start = 0; b1.clr_value = 0;
        for (int i = 0; i < 8; i++) m_mem[i] = 16'h0000;
        m_left = 0; m_idx = 0; m_val = 0; m_rv = 0; m_rd = 0;
        repeat (2) @(negedge clk);
        b0.wr_valid = 1'b1;
        #1;
        chk("rst_ram_load", {31'd0, b0.ram_load}, 32'd0);
        chk("rst_busy", {31'd0, b0.busy}, 32'd0);
        chk("rst_rvld", {31'd0, b0.rd_data_valid}, 32'd0);
        chk("rst_rdata", {16'd0, b0.rd_data}, 32'd0);
        @(negedge clk);
        b0.wr_valid = 1'b0;
        rst0 = 1'b0;

        // Initialise the ram to zero through a sweep.
        cyc(0, 0, 0, 0, 0, 1, 16'h0000);
        repeat (8) idle();

        cyc(1, 3'd5, 16'hBEEF, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 3'd5, 0, 0);
        chk("t1_beef", {16'd0, b0.rd_data}, 32'h0000BEEF);
        idle();

        cyc(0, 0, 0, 0, 0, 1, 16'hA5A5);
        for (int i = 0; i < 8; i++) cyc(i[0], 3'd3, 16'h1111, 1, 3'd1, (i == 3), 16'h5A5A);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 0, 1, i[2:0], 0, 0);
            chk("t2_fill", {16'd0, b0.rd_data}, 32'h0000A5A5);
        end

        cyc(1, 3'd6, 16'hC0DE, 1, 3'd6, 0, 0);
        cyc(0, 0, 0, 1, 3'd6, 0, 0);
        chk("t3_wr_rd", {16'd0, b0.rd_data}, 32'h0000C0DE);

        cyc(1, 3'd2, 16'h1234, 0, 0, 1, 16'h0F0F);
        repeat (8) cyc(1, 3'd2, 16'h1234, 0, 0, 0, 0);
        cyc(1, 3'd2, 16'h1234, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 3'd2, 0, 0);
        chk("t4_after_clr", {16'd0, b0.rd_data}, 32'h00001234);

        cyc(0, 0, 0, 0, 0, 1, 16'h0000);
        repeat (8) idle();
        cyc(0, 0, 0, 0, 0, 1, 16'hFFFF);
        repeat (4) idle();
        rst0 = 1'b1;
        #1;
        chk("t5_load_abort", {31'd0, b0.ram_load}, 32'd0);
        chk("t5_busy_abort", {31'd0, b0.busy}, 32'd0);
        @(negedge clk);
        rst0 = 1'b0;
        m_left = 0; m_rv = 0; m_rd = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 0, 1, i[2:0], 0, 0);
            chk("t5_partial", {16'd0, b0.rd_data}, (i < 4) ? 32'h0000FFFF : 32'h00000000);
        end

        for (int n = 0; n < 400; n++) begin
            cyc(1'($urandom_range(0, 2) == 0), 3'($urandom), 16'($urandom),
                1'($urandom_range(0, 1)), 3'($urandom),
                1'($urandom_range(0, 24) == 0), 16'($urandom));
        end

        // Automatic sweep instance: requests are refused on the first edge after release.
        b1.wr_valid = 1'b1; b1.wr_addr = 3'd1; b1.wr_data = 16'h7777;
        rst1 = 1'b0;
        #1;
        chk("auto_wr_ready", {31'd0, b1.wr_ready}, 32'd0);
        @(posedge clk); @(negedge clk);
        b1.wr_valid = 1'b0;
        chk("auto_busy", {31'd0, b1.busy}, 32'd1);
        repeat (7) @(negedge clk);
        chk("auto_busy_end", {31'd0, b1.busy}, 32'd1);
        @(negedge clk);
        chk("auto_busy_low", {31'd0, b1.busy}, 32'd0);
        for (int i = 0; i < 8; i++) rd1(i[2:0], 16'h0042);
        for (int i = 0; i < 3; i++) begin
            b1.wr_valid = 1'b1; b1.wr_addr = 3'(i); b1.wr_data = 16'(i + 16'h100);
            @(posedge clk); @(negedge clk);
        end
        b1.wr_valid = 1'b0;
`ifdef RAM8_CTRL_STATS_EN
        chk("wr_count", {16'd0, wc1}, 32'd3);
`endif
        rd1(3'd2, 16'h0102);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
